// File: rtl/hits_run_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : hits_run_sequencer_if
// Description : Host/config and hit-generator signal bundle for the
//               hit-simulator run controller. The per-orbit statistics
//               signals exist only when ORBIT_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface hits_run_sequencer_if #(
  parameter int RAND_BITS = 7,
  parameter int ORBIT_W   = 16,
  parameter int CNT_W     = 32,
  parameter int BCID_W    = 12
);
  // host / config side
  logic                 cfg_we;
  logic [RAND_BITS-1:0] cfg_occupancy;
  logic                 start;
  logic                 abort;
  logic [ORBIT_W-1:0]   num_orbits;
  // generator side
  logic                 hits_in;
  logic [RAND_BITS-1:0] occupancy_out;
  logic                 gen_rst;
  // run status
  logic                 sample_valid;
  logic [BCID_W-1:0]    bcid;
  logic [ORBIT_W-1:0]   orbit_cnt;
  logic [CNT_W-1:0]     hit_count;
  logic                 busy;
  logic                 done;
`ifdef ORBIT_STATS_EN
  logic [CNT_W-1:0]     orbit_hits;
  logic                 orbit_strobe;
`endif

  // run controller view
  modport slave (
`ifdef ORBIT_STATS_EN
    output orbit_hits, orbit_strobe,
`endif
    input  cfg_we, cfg_occupancy, start, abort, num_orbits, hits_in,
    output occupancy_out, gen_rst, sample_valid, bcid, orbit_cnt,
           hit_count, busy, done
  );

  // host / generator view
  modport master (
`ifdef ORBIT_STATS_EN
    input  orbit_hits, orbit_strobe,
`endif
    output cfg_we, cfg_occupancy, start, abort, num_orbits, hits_in,
    input  occupancy_out, gen_rst, sample_valid, bcid, orbit_cnt,
           hit_count, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/hits_run_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : hits_run_sequencer
// Description : Run controller for the rng/hit-position/bunch-train chain.
//               Holds the generator in reset between runs, arms it, then
//               frames num_orbits orbits of BUNCH_POS crossings while
//               counting hits (saturating). Optional macro ORBIT_STATS_EN
//               adds per-orbit hit totals (orbit_hits / orbit_strobe).
// Revision    : 1.0 - initial release
// ============================================================================
module hits_run_sequencer #(
  parameter int RAND_BITS  = 7,
  parameter int BUNCH_POS  = 3564,
  parameter int ORBIT_W    = 16,
  parameter int CNT_W      = 32,
  parameter int ARM_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  hits_run_sequencer_if.slave  bus
);
  localparam int BCID_W = $clog2(BUNCH_POS);
  localparam int ARM_W  = $clog2(ARM_CYCLES + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [BCID_W-1:0] BCID_LAST = BCID_W'(BUNCH_POS - 1);
  localparam logic [ARM_W-1:0]  ARM_LAST  = ARM_W'(ARM_CYCLES - 1);

  logic [1:0]         state;
  logic [ORBIT_W-1:0] target;
  logic [ARM_W-1:0]   arm_cnt;

  logic               wrap;
  logic [ORBIT_W-1:0] orbit_next;
  logic [CNT_W-1:0]   hit_next;

  assign wrap       = (bus.bcid == BCID_LAST);
  assign orbit_next = bus.orbit_cnt + ORBIT_W'(1);
  // hold at all-ones instead of rolling over
  assign hit_next   = (&bus.hit_count) ? bus.hit_count
                                       : bus.hit_count + CNT_W'(bus.hits_in);

  // run state machine and all registered run outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= S_IDLE;
      target            <= '0;
      arm_cnt           <= '0;
      bus.occupancy_out <= '0;
      bus.gen_rst       <= 1'b1;
      bus.sample_valid  <= 1'b0;
      bus.bcid          <= '0;
      bus.orbit_cnt     <= '0;
      bus.hit_count     <= '0;
      bus.busy          <= 1'b0;
      bus.done          <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.cfg_we) bus.occupancy_out <= bus.cfg_occupancy;
          if (bus.start) begin
            target        <= bus.num_orbits;
            arm_cnt       <= '0;
            bus.bcid      <= '0;
            bus.orbit_cnt <= '0;
            bus.hit_count <= '0;
            if (bus.num_orbits == '0) begin
              // empty run: report completion without touching the generator
              state    <= S_DONE;
              bus.done <= 1'b1;
            end else begin
              state       <= S_ARM;
              bus.gen_rst <= 1'b0;
              bus.busy    <= 1'b1;
            end
          end
        end
        S_ARM: begin
          if (bus.abort) begin
            state       <= S_IDLE;
            bus.gen_rst <= 1'b1;
            bus.busy    <= 1'b0;
          end else if (arm_cnt == ARM_LAST) begin
            state            <= S_RUN;
            bus.sample_valid <= 1'b1;
          end else begin
            arm_cnt <= arm_cnt + ARM_W'(1);
          end
        end
        S_RUN: begin
          // abort wins over counting and over orbit completion
          if (bus.abort) begin
            state            <= S_IDLE;
            bus.gen_rst      <= 1'b1;
            bus.busy         <= 1'b0;
            bus.sample_valid <= 1'b0;
          end else begin
            bus.hit_count <= hit_next;
            if (wrap) begin
              bus.bcid      <= '0;
              bus.orbit_cnt <= orbit_next;
              if (orbit_next == target) begin
                state            <= S_DONE;
                bus.done         <= 1'b1;
                bus.busy         <= 1'b0;
                bus.gen_rst      <= 1'b1;
                bus.sample_valid <= 1'b0;
              end
            end else begin
              bus.bcid <= bus.bcid + BCID_W'(1);
            end
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef ORBIT_STATS_EN
  logic [CNT_W-1:0] orbit_acc;
  logic [CNT_W-1:0] acc_next;

  assign acc_next = (&orbit_acc) ? orbit_acc : orbit_acc + CNT_W'(bus.hits_in);

  // per-orbit accumulator, published and cleared at every bcid wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      orbit_acc        <= '0;
      bus.orbit_hits   <= '0;
      bus.orbit_strobe <= 1'b0;
    end else begin
      bus.orbit_strobe <= 1'b0;
      if (state == S_IDLE && bus.start) begin
        orbit_acc <= '0;
      end else if (state == S_RUN && !bus.abort) begin
        if (wrap) begin
          bus.orbit_hits   <= acc_next;
          bus.orbit_strobe <= 1'b1;
          orbit_acc        <= '0;
        end else begin
          orbit_acc <= acc_next;
        end
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_hits_run_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_hits_run_sequencer
// Description : Self-checking bench for hits_run_sequencer. Two instances
//               (32-bit and 4-bit hit counters) share one stimulus stream;
//               expected outputs come from a cycle-timeline model of a run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hits_run_sequencer;
  localparam int BP  = 8;
  localparam int ARM = 4;
  localparam int RB  = 7;
  localparam int OW  = 16;
  localparam int CW  = 32;
  localparam int CW4 = 4;
  localparam int BW  = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hits_run_sequencer_if #(.RAND_BITS(RB), .ORBIT_W(OW), .CNT_W(CW),  .BCID_W(BW)) bus  ();
  hits_run_sequencer_if #(.RAND_BITS(RB), .ORBIT_W(OW), .CNT_W(CW4), .BCID_W(BW)) bus4 ();

  assign bus4.cfg_we        = bus.cfg_we;
  assign bus4.cfg_occupancy = bus.cfg_occupancy;
  assign bus4.start         = bus.start;
  assign bus4.abort         = bus.abort;
  assign bus4.num_orbits    = bus.num_orbits;
  assign bus4.hits_in       = bus.hits_in;

  hits_run_sequencer #(.RAND_BITS(RB), .BUNCH_POS(BP), .ORBIT_W(OW), .CNT_W(CW),
                       .ARM_CYCLES(ARM)) dut (.clk(clk), .rst(rst), .bus(bus));
  hits_run_sequencer #(.RAND_BITS(RB), .BUNCH_POS(BP), .ORBIT_W(OW), .CNT_W(CW4),
                       .ARM_CYCLES(ARM)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  int checks = 0;
  int errors = 0;

  // model state carried between runs
  logic [RB-1:0] exp_occ;
  longint        exp_ohits;
  bit            exp_ostb;
  int            hold_bc, hold_orb;
  longint        hold_sum;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input bit gr, input bit bz, input bit sv,
                         input bit dn, input int bc, input int orb, input longint sum);
    chk($sformatf("%s gen_rst", tag),      64'(bus.gen_rst),       64'(gr));
    chk($sformatf("%s busy", tag),         64'(bus.busy),          64'(bz));
    chk($sformatf("%s sample_valid", tag), 64'(bus.sample_valid),  64'(sv));
    chk($sformatf("%s done", tag),         64'(bus.done),          64'(dn));
    chk($sformatf("%s bcid", tag),         64'(bus.bcid),          64'(bc));
    chk($sformatf("%s orbit_cnt", tag),    64'(bus.orbit_cnt),     64'(orb));
    chk($sformatf("%s hit_count", tag),    64'(bus.hit_count),     64'(sum));
    chk($sformatf("%s hit_count_sat", tag), 64'(bus4.hit_count),   64'((sum > 15) ? 15 : sum));
    chk($sformatf("%s occupancy", tag),    64'(bus.occupancy_out), 64'(exp_occ));
`ifdef ORBIT_STATS_EN
    chk($sformatf("%s orbit_strobe", tag), 64'(bus.orbit_strobe),  64'(exp_ostb));
    chk($sformatf("%s orbit_hits", tag),   64'(bus.orbit_hits),    64'(exp_ohits));
`endif
  endtask

  task automatic chk_idle(input string tag);
    chk_out(tag, 1'b1, 1'b0, 1'b0, 1'b0, hold_bc, hold_orb, hold_sum);
  endtask

  // One run on the cycle timeline: start edge, ARM cycles, n*BP samples, DONE.
  // mode 0: hits all 1, 1: alternating from 1, 2: random.
  // abort_at/rst_at/inject_at name the sample index where that event is driven (-1 = none).
  task automatic do_run(input string name, input int n, input int mode, input int abort_at,
                        input int rst_at, input int inject_at, input bit cfg_with,
                        input logic [RB-1:0] occ);
    longint sum  = 0;
    longint osum = 0;
    int     len  = n * BP;
    bit     hv;
    bus.start      = 1'b1;
    bus.num_orbits = OW'(n);
    if (cfg_with) begin
      bus.cfg_we        = 1'b1;
      bus.cfg_occupancy = occ;
    end
    bus.hits_in = 1'b1;
    tick();
    if (cfg_with) exp_occ = occ;
    bus.start  = 1'b0;
    bus.cfg_we = 1'b0;
    exp_ostb   = 1'b0;
    for (int k = 1; k <= ARM; k++) begin
      chk_out($sformatf("%s arm%0d", name, k), 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0);
      tick();
    end
    for (int s = 0; s < len; s++) begin
      chk_out($sformatf("%s s%0d", name, s), 1'b0, 1'b1, 1'b1, 1'b0, s % BP, s / BP, sum);
      exp_ostb = 1'b0;
      if (s == rst_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_occ = '0; exp_ohits = 0;
        hold_bc = 0; hold_orb = 0; hold_sum = 0;
        chk_out($sformatf("%s rst", name), 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        return;
      end
      if (s == abort_at) begin
        bus.abort   = 1'b1;
        bus.hits_in = 1'b1;
        tick();
        bus.abort = 1'b0;
        hold_bc = s % BP; hold_orb = s / BP; hold_sum = sum;
        chk_idle($sformatf("%s abort", name));
        tick();
        chk_idle($sformatf("%s abort+1", name));
        return;
      end
      case (mode)
        0:       hv = 1'b1;
        1:       hv = (s % 2 == 0);
        default: hv = 1'($urandom_range(0, 1));
      endcase
      bus.hits_in = hv;
      if (s == inject_at) begin
        bus.cfg_we = 1'b1; bus.cfg_occupancy = 7'd99;
        bus.start  = 1'b1; bus.num_orbits    = 16'd9;
      end
      sum  += longint'(hv);
      osum += longint'(hv);
      if (s % BP == BP - 1) begin
        exp_ohits = osum;
        exp_ostb  = 1'b1;
        osum      = 0;
      end
      tick();
      bus.cfg_we = 1'b0;
      bus.start  = 1'b0;
    end
    chk_out($sformatf("%s done", name), 1'b1, 1'b0, 1'b0, 1'b1, 0, n, sum);
    exp_ostb = 1'b0;
    hold_bc = 0; hold_orb = n; hold_sum = sum;
    tick();
    chk_idle($sformatf("%s idle", name));
  endtask

  initial begin
    int n;
    int a;
    int gap;
    logic [RB-1:0] o;
    rst = 1'b1;
    bus.cfg_we = 1'b0; bus.cfg_occupancy = '0; bus.start = 1'b0;
    bus.abort = 1'b0;  bus.num_orbits = '0;    bus.hits_in = 1'b0;
    exp_occ = '0; exp_ohits = 0; exp_ostb = 1'b0;
    hold_bc = 0; hold_orb = 0; hold_sum = 0;
    tick();
    tick();
    chk_idle("reset");

    // load occupancy, then check abort in IDLE does nothing
    rst = 1'b0;
    bus.cfg_we = 1'b1; bus.cfg_occupancy = 7'd40;
    tick();
    bus.cfg_we = 1'b0;
    exp_occ = 7'd40;
    chk_idle("cfg40");
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk_idle("idle_abort");

    // basic run; the 4-bit instance saturates at 15
    do_run("basic", 3, 0, -1, -1, -1, 1'b0, '0);

    // zero orbits: immediate done, counters cleared, never busy
    bus.start = 1'b1; bus.num_orbits = '0;
    tick();
    bus.start = 1'b0;
    chk_out("zero done", 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 0);
    hold_bc = 0; hold_orb = 0; hold_sum = 0;
    tick();
    chk_idle("zero idle");

    // abort at bcid 5 of orbit 1 with alternating hits
    do_run("abort", 3, 1, BP + 5, -1, -1, 1'b0, '0);

    // cfg_we/start during RUN are ignored
    do_run("ignore", 2, 2, -1, -1, 3, 1'b0, '0);
    bus.cfg_we = 1'b1; bus.cfg_occupancy = 7'd99;
    tick();
    bus.cfg_we = 1'b0;
    exp_occ = 7'd99;
    chk_idle("cfg99");

    // randomized runs, occupancy written together with start
    for (int r = 0; r < 5; r++) begin
      n   = int'($urandom_range(1, 3));
      a   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n * BP - 1)) : -1;
      o   = RB'($urandom);
      gap = int'($urandom_range(0, 2));
      do_run($sformatf("rnd%0d", r), n, 2, a, -1, -1, 1'b1, o);
      for (int g = 0; g < gap; g++) begin
        tick();
        chk_idle($sformatf("rnd%0d gap%0d", r, g));
      end
    end

    // reset in the middle of orbit 1
    do_run("rstmid", 2, 0, -1, BP + 3, -1, 1'b0, '0);
    tick();
    chk_idle("post_rst");

    // the block runs normally again after the mid-run reset
    do_run("final", 1, 2, -1, -1, -1, 1'b1, 7'd17);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
